// File: rtl/agc_ctl_pkg.sv
// Shared constants for the AGC control-section rupt/SQ logic.
// Holds the default rupt vector layout, the SQ field position on the write bus and the index-width helper.
package agc_ctl_pkg;

   localparam logic [11:0] RPT_BASE_DEF   = 12'o4000;
   localparam int          RPT_STRIDE_DEF = 4;

   // SQ is always taken from the top bits of the write bus, downward from this bit.
   localparam int SQ_MSB = 15;
   localparam int WL_W   = 16;

   function automatic int rpt_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/agc_prio_enc.sv
// Lowest-index-first priority encoder used for rupt arbitration.
// Purely combinational; idx is only meaningful while valid is high.
module agc_prio_enc
   import agc_ctl_pkg::*;
#(
   parameter int N  = 10,
   parameter int IW = rpt_idx_w(N)
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/agc_rupt_seq.sv
// Interrupt-priority and sequence-register block: latches rupt requests, arbitrates at nisq and loads SQ otherwise.
// Optional per-channel mask register is enabled by defining AGC_RUPT_MASK_EN.
module agc_rupt_seq
   import agc_ctl_pkg::*;
#(
   parameter int          NRUPT      = 10,
   parameter int          SQW        = 6,
   parameter logic [11:0] RPT_BASE   = RPT_BASE_DEF,
   parameter int          RPT_STRIDE = RPT_STRIDE_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          gojam,
   input  logic                          nisq,
   input  logic [15:0]                   wl,
   input  logic [NRUPT-1:0]              rupt_req,
   input  logic                          inhpls,
   input  logic                          relpls,
   input  logic                          ovnhrp,
   input  logic                          extpls,
   input  logic                          resume,
   input  logic                          mask_we,
   input  logic [NRUPT-1:0]              mask_d,
   output logic [SQW-1:0]                sq,
   output logic                          sqext,
   output logic                          futext,
   output logic                          inhint,
   output logic                          iip,
   output logic [NRUPT-1:0]              rpt_pend,
   output logic                          rpt_take,
   output logic [rpt_idx_w(NRUPT)-1:0]   rpt_idx,
   output logic [11:0]                   rpt_addr
);

   localparam int IW = rpt_idx_w(NRUPT);

   logic [NRUPT-1:0] mask;
   logic [NRUPT-1:0] eligible;
   logic             enc_valid;
   logic [IW-1:0]    enc_idx;
   logic             take;
   logic [NRUPT-1:0] take_clr;

`ifdef AGC_RUPT_MASK_EN
   // The mask survives gojam; only a hard reset re-enables every channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask <= '1;
      end else if (mask_we) begin
         mask <= mask_d;
      end
   end
`else
   logic unused_mask_inputs;
   assign unused_mask_inputs = ^{mask_we, mask_d};
   assign mask = '1;
`endif

   assign eligible = rpt_pend & mask;

   agc_prio_enc #(
      .N  (NRUPT),
      .IW (IW)
   ) u_prio_enc (
      .req   (eligible),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   always_comb begin
      take     = nisq & enc_valid & ~inhint & ~iip & ~futext & ~ovnhrp;
      take_clr = '0;
      if (take) begin
         take_clr = NRUPT'(1) << enc_idx;
      end
   end

   // New requests are OR'd in after the taken bit is cleared, so a same-cycle request keeps the channel pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         sq       <= '0;
         sqext    <= 1'b0;
         futext   <= 1'b0;
         inhint   <= 1'b0;
         iip      <= 1'b0;
         rpt_pend <= '0;
         rpt_take <= 1'b0;
         rpt_idx  <= '0;
         rpt_addr <= RPT_BASE;
      end else if (gojam) begin
         sqext    <= 1'b0;
         futext   <= 1'b0;
         inhint   <= 1'b0;
         iip      <= 1'b0;
         rpt_pend <= '0;
         rpt_take <= 1'b0;
      end else begin
         rpt_pend <= (rpt_pend & ~take_clr) | rupt_req;
         rpt_take <= take;

         if (take) begin
            rpt_idx  <= enc_idx;
            rpt_addr <= RPT_BASE + 12'(RPT_STRIDE) * 12'(enc_idx);
            iip      <= 1'b1;
         end else if (resume) begin
            iip <= 1'b0;
         end

         if (nisq && !take) begin
            sq    <= wl[SQ_MSB -: SQW];
            sqext <= futext;
         end

         // extpls wins over the nisq clear so an EXTEND right at nisq applies to the following instruction.
         if (extpls) begin
            futext <= 1'b1;
         end else if (nisq && !take) begin
            futext <= 1'b0;
         end

         if (inhpls) begin
            inhint <= 1'b1;
         end else if (relpls) begin
            inhint <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_agc_rupt_seq.sv
// Scoreboard bench for agc_rupt_seq: a behavioural model queues expected outputs per edge, a monitor compares them.
// Directed scenarios from the test plan run first, followed by randomized traffic.
module tb_agc_rupt_seq;

   localparam int NRUPT = 10;
   localparam int SQW   = 6;
   localparam int IW    = (NRUPT <= 1) ? 1 : $clog2(NRUPT);

   logic             clk = 1'b0;
   logic             rst, gojam, nisq, inhpls, relpls, ovnhrp, extpls, resume, mask_we;
   logic [15:0]      wl;
   logic [NRUPT-1:0] rupt_req, mask_d;
   logic [SQW-1:0]   sq;
   logic             sqext, futext, inhint, iip, rpt_take;
   logic [NRUPT-1:0] rpt_pend;
   logic [IW-1:0]    rpt_idx;
   logic [11:0]      rpt_addr;

   agc_rupt_seq #(.NRUPT(NRUPT), .SQW(SQW), .RPT_BASE(12'o4000), .RPT_STRIDE(4)) dut (
      .clk(clk), .rst(rst), .gojam(gojam), .nisq(nisq), .wl(wl), .rupt_req(rupt_req),
      .inhpls(inhpls), .relpls(relpls), .ovnhrp(ovnhrp), .extpls(extpls), .resume(resume),
      .mask_we(mask_we), .mask_d(mask_d), .sq(sq), .sqext(sqext), .futext(futext),
      .inhint(inhint), .iip(iip), .rpt_pend(rpt_pend), .rpt_take(rpt_take),
      .rpt_idx(rpt_idx), .rpt_addr(rpt_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SQW-1:0]   sq;
      logic             sqext;
      logic             futext;
      logic             inhint;
      logic             iip;
      logic [NRUPT-1:0] pend;
      logic             take;
      logic [IW-1:0]    idx;
      logic [11:0]      addr;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   logic [NRUPT-1:0] m_mask;
   int npass = 0;
   int ntotal = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      ntotal++;
      if (act === want) npass++;
      else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, want, $time);
   endtask

   task automatic clearInputs();
      rst = 0; gojam = 0; nisq = 0; inhpls = 0; relpls = 0; ovnhrp = 0;
      extpls = 0; resume = 0; mask_we = 0; rupt_req = '0; mask_d = '0;
   endtask

   // Reference model: one edge of behaviour from the rules, using pre-edge state and inputs.
   task automatic modelStep();
      exp_t n;
      int   win;
      bit   go;
      n = m;
      n.take = 0;
      if (rst) begin
         n = '0;
         n.addr = 12'o4000;
         m_mask = '1;
      end else if (gojam) begin
         n.pend = '0; n.iip = 0; n.futext = 0; n.inhint = 0; n.sqext = 0;
      end else begin
         win = -1;
         for (int i = 0; i < NRUPT; i++) begin
            if (win < 0 && m.pend[i] && m_mask[i]) win = i;
         end
         go = nisq && (win >= 0) && !m.inhint && !m.iip && !m.futext && !ovnhrp;
         if (go) begin
            n.pend[win] = 1'b0;
            n.take = 1;
            n.idx  = IW'(win);
            n.addr = 12'(2048 + 4 * win);
            n.iip  = 1;
         end else if (resume) begin
            n.iip = 0;
         end
         n.pend = n.pend | rupt_req;
         if (nisq && !go) begin
            n.sq     = SQW'(wl / (1 << (16 - SQW)));
            n.sqext  = m.futext;
            n.futext = 0;
         end
         if (extpls) n.futext = 1;
         if (inhpls) n.inhint = 1;
         else if (relpls) n.inhint = 0;
`ifdef AGC_RUPT_MASK_EN
         if (mask_we) m_mask = mask_d;
`endif
      end
      m = n;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      exp_q.push_back(m);
      #1;
      clearInputs();
   endtask

   task automatic checkOutput(input exp_t e);
      chk("sq", 32'(sq), 32'(e.sq));
      chk("sqext", 32'(sqext), 32'(e.sqext));
      chk("futext", 32'(futext), 32'(e.futext));
      chk("inhint", 32'(inhint), 32'(e.inhint));
      chk("iip", 32'(iip), 32'(e.iip));
      chk("rpt_pend", 32'(rpt_pend), 32'(e.pend));
      chk("rpt_take", 32'(rpt_take), 32'(e.take));
      if (e.take) chk("rpt_idx", 32'(rpt_idx), 32'(e.idx));
      chk("rpt_addr", 32'(rpt_addr), 32'(e.addr));
   endtask

   // Monitor: every edge with a queued expectation is compared just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   initial begin
      int k;
      m = '0;
      m_mask = '1;
      wl = '0;
      clearInputs();

      rst = 1; applyStimulus();
      rst = 1; applyStimulus();
      chk("reset_addr", 32'(rpt_addr), 32'o4000);
      chk("reset_pend", 32'(rpt_pend), 32'd0);

      rupt_req = 10'b0000100100; applyStimulus();
      nisq = 1; applyStimulus();
      chk("tp1_take", 32'(rpt_take), 32'd1);
      chk("tp1_idx", 32'(rpt_idx), 32'd2);
      chk("tp1_addr", 32'(rpt_addr), 32'o4010);
      chk("tp1_pend", 32'(rpt_pend), 32'b0000100000);

      gojam = 1; inhpls = 1; extpls = 1; rupt_req = '1; applyStimulus();
      chk("gojam_iip", 32'(iip), 32'd0);
      chk("gojam_inhint", 32'(inhint), 32'd0);
      wl = 16'o054321; nisq = 1; applyStimulus();
      chk("tp2_sq", 32'(sq), 32'o26);
      chk("tp2_take", 32'(rpt_take), 32'd0);

      extpls = 1; applyStimulus();
      wl = 16'o030000; nisq = 1; applyStimulus();
      chk("tp3_sqext", 32'(sqext), 32'd1);
      chk("tp3_futext", 32'(futext), 32'd0);

      inhpls = 1; rupt_req = 10'b0000100000; applyStimulus();
      nisq = 1; applyStimulus();
      chk("tp4_inh_notake", 32'(rpt_take), 32'd0);
      relpls = 1; applyStimulus();
      nisq = 1; applyStimulus();
      chk("tp4_idx5", 32'(rpt_idx), 32'd5);

      resume = 1; applyStimulus();
      mask_we = 1; mask_d = 10'b1111111110; applyStimulus();
      rupt_req = 10'b0000000011; applyStimulus();
      nisq = 1; rupt_req = 10'b0000001000; applyStimulus();
`ifdef AGC_RUPT_MASK_EN
      chk("mask_idx", 32'(rpt_idx), 32'd1);
`else
      chk("mask_idx", 32'(rpt_idx), 32'd0);
`endif
      rst = 1; applyStimulus();

      for (int c = 0; c < 3000; c++) begin
         wl       = 16'($urandom);
         rupt_req = NRUPT'($urandom & $urandom & $urandom);
         nisq     = ($urandom_range(0, 2) == 0);
         inhpls   = ($urandom_range(0, 9) == 0);
         relpls   = ($urandom_range(0, 5) == 0);
         ovnhrp   = ($urandom_range(0, 7) == 0);
         extpls   = ($urandom_range(0, 9) == 0);
         resume   = ($urandom_range(0, 4) == 0);
         gojam    = ($urandom_range(0, 59) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         mask_we  = !gojam && ($urandom_range(0, 39) == 0);
         mask_d   = NRUPT'($urandom);
         applyStimulus();
      end

      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
